// File: rtl/cmp_storage_pkg.sv
// Shared constants and the storage-element mode selector for cmp_storage_elements.
package cmp_storage_pkg;

  // Default data width of D and of each Q output.
  localparam int DEFAULT_WIDTH = 1;

  // Default reset bit, replicated across the full word by each element.
  localparam bit DEFAULT_RST_VAL = 1'b0;

  // Which kind of storage a stor_elem instance builds.
  typedef enum logic [1:0] {
    LATCH_HI = 2'd0,
    FF_POS   = 2'd1,
    FF_NEG   = 2'd2
  } stor_mode_e;

endpackage

// File: rtl/stor_elem.sv
// One storage element: high-transparent latch, rising-edge flop or falling-edge flop.
// Reset is synchronous to whatever makes the element update (its edge or its enable level).
module stor_elem
  import cmp_storage_pkg::*;
#(
  parameter int         WIDTH   = DEFAULT_WIDTH,
  parameter bit         RST_VAL = DEFAULT_RST_VAL,
  parameter stor_mode_e MODE    = FF_POS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_VAL}};

  if (MODE == LATCH_HI) begin : g_latch
    // Deliberate latch: transparent (or resetting) while clk is high, holds while clk is low.
    always_latch begin
      if (clk) begin
        q = rst ? RST_WORD : d;
      end
    end
  end else if (MODE == FF_NEG) begin : g_ff_neg
    // Falling-edge capture; reset only takes effect if present at the falling edge.
    always_ff @(negedge clk) begin
      if (rst) begin
        q <= RST_WORD;
      end else begin
        q <= d;
      end
    end
  end else begin : g_ff_pos
    // Rising-edge capture; reset only takes effect if present at the rising edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= RST_WORD;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/cmp_storage_elements.sv
// Side-by-side latch / posedge flop / negedge flop, all fed by the same D and clock.
// Pure wiring: each output comes from its own stor_elem instance.
module cmp_storage_elements
  import cmp_storage_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit RST_VAL = DEFAULT_RST_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  output logic [WIDTH-1:0] Qc
);

  stor_elem #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .MODE(LATCH_HI)) u_latch (
    .clk (clk),
    .rst (rst),
    .d   (D),
    .q   (Qa)
  );

  stor_elem #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .MODE(FF_POS)) u_ff_pos (
    .clk (clk),
    .rst (rst),
    .d   (D),
    .q   (Qb)
  );

  stor_elem #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .MODE(FF_NEG)) u_ff_neg (
    .clk (clk),
    .rst (rst),
    .d   (D),
    .q   (Qc)
  );

endmodule

// File: tb/tb_cmp_storage_elements.sv
// Directed bench for cmp_storage_elements: a 1-bit and an 8-bit instance share clk and rst.
// Clock period 20 ns, low at t=0, rising at 10, 30, 50, ...
`timescale 1ns/1ps
module tb_cmp_storage_elements;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       qa1, qb1, qc1;
  logic [7:0] d8;
  logic [7:0] qa8, qb8, qc8;

  int total;
  int bad;

  cmp_storage_elements #(.WIDTH(1), .RST_VAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Qa  (qa1),
    .Qb  (qb1),
    .Qc  (qc1)
  );

  cmp_storage_elements #(.WIDTH(8), .RST_VAL(1'b0)) dut8 (
    .clk (clk),
    .rst (rst),
    .D   (d8),
    .Qa  (qa8),
    .Qb  (qb8),
    .Qc  (qc8)
  );

  // Free-running clock, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Drive every input at once so each stimulus step is one line.
  task automatic applyStimulus(input logic r, input logic dv, input logic [7:0] d8v);
    rst = r;
    d1  = dv;
    d8  = d8v;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  // Advance to an absolute time in ns.
  task automatic goTo(input realtime t);
    #(t - $realtime);
  endtask

  // Single 1-bit output check helper: widens to the common checking width.
  task automatic check1(input string tag, input logic got, input logic exp);
    checkOutput(tag, {7'd0, got}, {7'd0, exp});
  endtask

  // Directed timeline; every check sits at least 0.5 ns away from clock edges and input changes.
  initial begin
    total = 0;
    bad   = 0;

    applyStimulus(1'b1, 1'b1, 8'hFF);

    goTo(24);
    check1("rst_qa", qa1, 1'b0);
    check1("rst_qb", qb1, 1'b0);
    check1("rst_qc", qc1, 1'b0);
    checkOutput("rst_qa8", qa8, 8'h00);
    checkOutput("rst_qb8", qb8, 8'h00);
    checkOutput("rst_qc8", qc8, 8'h00);

    goTo(25);
    applyStimulus(1'b0, 1'b1, 8'hFF);

    goTo(35);
    check1("pos30_qa", qa1, 1'b1);
    check1("pos30_qb", qb1, 1'b1);
    check1("pos30_qc", qc1, 1'b0);

    goTo(44);
    check1("neg40_qa", qa1, 1'b1);
    check1("neg40_qb", qb1, 1'b1);
    check1("neg40_qc", qc1, 1'b1);
    checkOutput("neg40_qc8", qc8, 8'hFF);

    goTo(45);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    goTo(48);
    check1("hold_qa", qa1, 1'b1);
    check1("hold_qb", qb1, 1'b1);
    check1("hold_qc", qc1, 1'b1);

    goTo(50.5);
    check1("pos50_qa", qa1, 1'b0);
    check1("pos50_qb", qb1, 1'b0);

    goTo(51);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    goTo(52);
    check1("glitch1_qa", qa1, 1'b1);
    check1("glitch1_qb", qb1, 1'b0);
    goTo(53);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    goTo(54);
    check1("glitch2_qa", qa1, 1'b0);
    goTo(56);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    goTo(57);
    check1("glitch3_qa", qa1, 1'b1);
    goTo(59);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    goTo(59.5);
    check1("glitch4_qa", qa1, 1'b0);
    check1("glitch4_qb", qb1, 1'b0);
    check1("glitch4_qc", qc1, 1'b1);

    goTo(61);
    check1("neg60_qc", qc1, 1'b0);
    check1("neg60_qa", qa1, 1'b0);

    goTo(65);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    goTo(66);
    check1("lowd_qa", qa1, 1'b0);
    check1("lowd_qb", qb1, 1'b0);
    check1("lowd_qc", qc1, 1'b0);

    goTo(71);
    check1("pos70_qa", qa1, 1'b1);
    check1("pos70_qb", qb1, 1'b1);
    check1("pos70_qc", qc1, 1'b0);

    goTo(81);
    check1("neg80_qa", qa1, 1'b1);
    check1("neg80_qb", qb1, 1'b1);
    check1("neg80_qc", qc1, 1'b1);

    goTo(85);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    goTo(91);
    check1("mrst90_qa", qa1, 1'b0);
    check1("mrst90_qb", qb1, 1'b0);
    check1("mrst90_qc", qc1, 1'b1);

    goTo(101);
    check1("mrst100_qa", qa1, 1'b0);
    check1("mrst100_qb", qb1, 1'b0);
    check1("mrst100_qc", qc1, 1'b0);
    checkOutput("mrst100_qa8", qa8, 8'h00);
    checkOutput("mrst100_qb8", qb8, 8'h00);
    checkOutput("mrst100_qc8", qc8, 8'h00);

    goTo(105);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    goTo(121);
    check1("recover_qa", qa1, 1'b1);
    check1("recover_qb", qb1, 1'b1);
    check1("recover_qc", qc1, 1'b1);

    goTo(125);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    goTo(126);
    check1("rstlow_qa", qa1, 1'b1);

    goTo(131);
    check1("prst130_qa", qa1, 1'b0);
    check1("prst130_qb", qb1, 1'b0);
    check1("prst130_qc", qc1, 1'b1);

    goTo(135);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    goTo(136);
    check1("relhi_qa", qa1, 1'b1);
    check1("relhi_qb", qb1, 1'b0);

    goTo(141);
    check1("neg140_qa", qa1, 1'b1);
    check1("neg140_qb", qb1, 1'b0);
    check1("neg140_qc", qc1, 1'b1);

    goTo(145);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    goTo(151);
    checkOutput("w8_pos150_qa", qa8, 8'hA5);
    checkOutput("w8_pos150_qb", qb8, 8'hA5);
    checkOutput("w8_pos150_qc", qc8, 8'hFF);

    goTo(155);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    goTo(156);
    checkOutput("w8_hi_qa", qa8, 8'h3C);
    checkOutput("w8_hi_qb", qb8, 8'hA5);

    goTo(161);
    checkOutput("w8_neg160_qa", qa8, 8'h3C);
    checkOutput("w8_neg160_qb", qb8, 8'hA5);
    checkOutput("w8_neg160_qc", qc8, 8'h3C);

    goTo(171);
    checkOutput("w8_pos170_qb", qb8, 8'h3C);
    checkOutput("w8_pos170_qc", qc8, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
